// File: rtl/batch_ser_pkg.sv
// Shared width helpers for the batch serializer FIFO; every width is derived
// from the instance parameters, nothing is fixed here.
package batch_ser_pkg;

    function automatic int unsigned ptrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned lvlWidth(input int unsigned depth);
        return ptrWidth(depth) + 1;
    endfunction

    // Bit offset of lane 'lane' inside a packed batch of dataW-wide words.
    function automatic int unsigned laneLsb(input int unsigned lane, input int unsigned dataW);
        return lane * dataW;
    endfunction

endpackage

// File: rtl/batch_ser_mem.sv
// Storage array for the batch serializer: one batch-aligned LANES-wide write
// port and one registered single-word read port.
module batch_ser_mem
    import batch_ser_pkg::*;
#(
    parameter int unsigned DATA_W  = 36,
    parameter int unsigned LANES   = 4,
    parameter int unsigned BATCHES = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             we_i,
    input  logic [$clog2(BATCHES)-1:0]       wbatch_i,
    input  logic [LANES*DATA_W-1:0]          wdata_i,
    input  logic                             re_i,
    input  logic [ptrWidth(LANES*BATCHES)-1:0] raddr_i,
    output logic [DATA_W-1:0]                rdata_o
);

    localparam int unsigned DEPTH  = LANES * BATCHES;
    localparam int unsigned LANE_W = $clog2(LANES);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // The array itself is never reset; the control logic decides what is valid.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                mem_q[{wbatch_i, LANE_W'(k)}] <= wdata_i[laneLsb(k, DATA_W) +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/batch_serializer_fifo.sv
// Multi-lane gather/serialise FIFO: one LANES-word batch in per write, one word
// out per read. Define BATCH_SER_ERR_EN to add sticky overflow/underflow outputs.
module batch_serializer_fifo
    import batch_ser_pkg::*;
#(
    parameter int unsigned DATA_W  = 36,
    parameter int unsigned LANES   = 4,
    parameter int unsigned BATCHES = 4,
    localparam int unsigned LVL_W  = lvlWidth(LANES * BATCHES)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [LANES*DATA_W-1:0] din_i,
    output logic                    wr_ready_o,
    input  logic                    rd_en_i,
    output logic [DATA_W-1:0]       dout_o,
    output logic                    dout_valid_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [LVL_W-1:0]        level_o,
    output logic                    frame_done_o
`ifdef BATCH_SER_ERR_EN
    ,
    output logic                    overflow_o,
    output logic                    underflow_o
`endif
);

    localparam int unsigned DEPTH   = LANES * BATCHES;
    localparam int unsigned PTR_W   = ptrWidth(DEPTH);
    localparam int unsigned BATCH_W = $clog2(BATCHES);

    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH - LANES);
    localparam logic [LVL_W-1:0] LANES_LVL = LVL_W'(LANES);
    localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(DEPTH - 1);

    // The write pointer is kept as a batch index; its lane bits are always zero.
    logic [BATCH_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   frameCnt_q, frameCnt_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               doutValid_q, doutValid_d;
    logic               frameDone_q, frameDone_d;
    logic               wrAcc, rdAcc;

    assign wrAcc = wr_en_i && !full_q;
    assign rdAcc = rd_en_i && !empty_q;

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        frameCnt_d  = frameCnt_q;
        level_d     = level_q + (wrAcc ? LANES_LVL : '0) - (rdAcc ? LVL_W'(1) : '0);
        full_d      = 1'b0;
        empty_d     = 1'b0;
        doutValid_d = rdAcc;
        frameDone_d = rdAcc && (frameCnt_q == LAST_WORD);
        if (wrAcc) begin
            wrPtr_d = wrPtr_q + BATCH_W'(1);
        end
        if (rdAcc) begin
            rdPtr_d    = rdPtr_q + PTR_W'(1);
            frameCnt_d = frameCnt_q + PTR_W'(1);
        end
        full_d  = level_d > FULL_LVL;
        empty_d = level_d == '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            frameCnt_q  <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            doutValid_q <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            frameCnt_q  <= frameCnt_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            doutValid_q <= doutValid_d;
            frameDone_q <= frameDone_d;
        end
    end

    batch_ser_mem #(
        .DATA_W  (DATA_W),
        .LANES   (LANES),
        .BATCHES (BATCHES)
    ) u_mem (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (wrAcc),
        .wbatch_i (wrPtr_q),
        .wdata_i  (din_i),
        .re_i     (rdAcc),
        .raddr_i  (rdPtr_q),
        .rdata_o  (dout_o)
    );

    assign wr_ready_o   = !full_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign level_o      = level_q;
    assign dout_valid_o = doutValid_q;
    assign frame_done_o = frameDone_q;

`ifdef BATCH_SER_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky until reset so software can poll after the fact.
    always_comb begin
        overflow_d  = overflow_q  | (wr_en_i & full_q);
        underflow_d = underflow_q | (rd_en_i & empty_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_batch_serializer_fifo.sv
// Self-checking bench for batch_serializer_fifo: a hand-computed vector table
// plus queue-model sequences for fill, concurrency, wrap and async reset.
module tb_batch_serializer_fifo;

    localparam int DATA_W  = 36;
    localparam int LANES   = 4;
    localparam int BATCHES = 4;
    localparam int DEPTH   = LANES * BATCHES;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int BW      = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [BW-1:0]     din = '0;
    logic              wr_ready, dout_valid, full, empty, frame_done;
    logic [DATA_W-1:0] dout;
    logic [LVL_W-1:0]  level;
`ifdef BATCH_SER_ERR_EN
    logic              overflow, underflow;
    bit                mOvf, mUnf;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    logic [DATA_W-1:0] mq[$];
    int                mLevel = 0;
    int                mReads = 0;
    logic [DATA_W-1:0] mDout = '0;
    bit                mValid = 0;
    bit                mFrame = 0;

    always #5 clk = ~clk;

    batch_serializer_fifo #(
        .DATA_W  (DATA_W),
        .LANES   (LANES),
        .BATCHES (BATCHES)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_en_i      (wr_en),
        .din_i        (din),
        .wr_ready_o   (wr_ready),
        .rd_en_i      (rd_en),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .full_o       (full),
        .empty_o      (empty),
        .level_o      (level),
        .frame_done_o (frame_done)
`ifdef BATCH_SER_ERR_EN
        ,
        .overflow_o   (overflow),
        .underflow_o  (underflow)
`endif
    );

    typedef struct {
        bit                wr;
        bit                rd;
        logic [BW-1:0]     din;
        logic [DATA_W-1:0] dout;
        bit                valid;
        int                level;
        bit                full;
        bit                empty;
        bit                frame;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] makeBatch(input int base);
        logic [BW-1:0] b;
        for (int k = 0; k < LANES; k++) begin
            b[k*DATA_W +: DATA_W] = {4'hA, 32'(base + k)};
        end
        return b;
    endfunction

    // One clock: drive inputs, advance the model with start-of-cycle flags, settle.
    task automatic applyStimulus(input bit wr, input logic [BW-1:0] d, input bit rd);
        bit wAcc, rAcc;
        wAcc = wr && (mLevel <= DEPTH - LANES);
        rAcc = rd && (mLevel != 0);
`ifdef BATCH_SER_ERR_EN
        if (wr && !wAcc) mOvf = 1;
        if (rd && mLevel == 0) mUnf = 1;
`endif
        wr_en = wr;
        din   = d;
        rd_en = rd;
        @(posedge clk);
        #1;
        mValid = rAcc;
        mFrame = 0;
        if (rAcc) begin
            mDout = mq.pop_front();
            mReads++;
            mFrame = (mReads % DEPTH) == 0;
        end
        if (wAcc) begin
            for (int k = 0; k < LANES; k++) mq.push_back(d[k*DATA_W +: DATA_W]);
        end
        mLevel = mLevel + (wAcc ? LANES : 0) - (rAcc ? 1 : 0);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".dout"},       dout,       mDout);
        checkOutput({tag, ".valid"},      dout_valid, mValid);
        checkOutput({tag, ".level"},      level,      mLevel);
        checkOutput({tag, ".full"},       full,       mLevel > DEPTH - LANES);
        checkOutput({tag, ".empty"},      empty,      mLevel == 0);
        checkOutput({tag, ".wr_ready"},   wr_ready,   mLevel <= DEPTH - LANES);
        checkOutput({tag, ".frame_done"}, frame_done, mFrame);
`ifdef BATCH_SER_ERR_EN
        checkOutput({tag, ".overflow"},   overflow,   mOvf);
        checkOutput({tag, ".underflow"},  underflow,  mUnf);
`endif
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".dout"},       dout,       0);
        checkOutput({tag, ".valid"},      dout_valid, 0);
        checkOutput({tag, ".level"},      level,      0);
        checkOutput({tag, ".full"},       full,       0);
        checkOutput({tag, ".empty"},      empty,      1);
        checkOutput({tag, ".wr_ready"},   wr_ready,   1);
        checkOutput({tag, ".frame_done"}, frame_done, 0);
`ifdef BATCH_SER_ERR_EN
        checkOutput({tag, ".overflow"},   overflow,   0);
        checkOutput({tag, ".underflow"},  underflow,  0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int validCnt, frameCnt;

        vecs[0] = '{1, 0, {36'd4, 36'd3, 36'd2, 36'd1}, 36'd0, 0, 4, 0, 0, 0};
        vecs[1] = '{0, 1, '0, 36'd1, 1, 3, 0, 0, 0};
        vecs[2] = '{0, 1, '0, 36'd2, 1, 2, 0, 0, 0};
        vecs[3] = '{0, 1, '0, 36'd3, 1, 1, 0, 0, 0};
        vecs[4] = '{0, 1, '0, 36'd4, 1, 0, 0, 1, 0};
        vecs[5] = '{0, 1, '0, 36'd4, 0, 0, 0, 1, 0};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("reset");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd);
            checkOutput($sformatf("vec%0d.dout", i),  dout,       vecs[i].dout);
            checkOutput($sformatf("vec%0d.valid", i), dout_valid, vecs[i].valid);
            checkOutput($sformatf("vec%0d.level", i), level,      vecs[i].level);
            checkOutput($sformatf("vec%0d.full", i),  full,       vecs[i].full);
            checkOutput($sformatf("vec%0d.empty", i), empty,      vecs[i].empty);
            checkOutput($sformatf("vec%0d.frame", i), frame_done, vecs[i].frame);
        end

        // Fill to DEPTH, then a dropped fifth write.
        for (int b = 0; b < BATCHES; b++) begin
            applyStimulus(1, makeBatch(16'h100 + b * LANES), 0);
            checkModel($sformatf("fill%0d", b));
        end
        checkOutput("fill.full_at_16",  full,     1);
        checkOutput("fill.ready_at_16", wr_ready, 0);
        applyStimulus(1, makeBatch(16'h900), 0);
        checkModel("drop");
        checkOutput("drop.level16", level, 16);

        for (int n = 0; n < LANES; n++) begin
            applyStimulus(0, '0, 1);
            checkModel($sformatf("rd%0d", n));
        end
        applyStimulus(1, makeBatch(16'h200), 1);
        checkModel("both12");
        checkOutput("both12.level15", level, 15);
        applyStimulus(0, '0, 1);
        applyStimulus(0, '0, 1);
        checkModel("down13");
        applyStimulus(1, makeBatch(16'h300), 1);
        checkModel("refuse13");
        checkOutput("refuse13.level12", level, 12);

        for (int n = 0; n < 64 && mLevel > 0; n++) begin
            applyStimulus(0, '0, 1);
            checkModel($sformatf("drain%0d", n));
        end

        applyStimulus(0, '0, 1);
        checkModel("emptyread");
        checkOutput("emptyread.valid0", dout_valid, 0);

        // Continuous stream forcing many pointer wraps.
        validCnt = 0;
        frameCnt = 0;
        for (int i = 0; i < 40 * LANES; i++) begin
            applyStimulus((i % LANES) == 0, makeBatch(16'h1000 + i), 1);
            checkModel($sformatf("stream%0d", i));
            validCnt += int'(dout_valid);
            frameCnt += int'(frame_done);
        end
        for (int n = 0; n < 64 && mLevel > 0; n++) begin
            applyStimulus(0, '0, 1);
            checkModel($sformatf("sdrain%0d", n));
            validCnt += int'(dout_valid);
            frameCnt += int'(frame_done);
        end
        checkOutput("stream.words", validCnt, 160);
        checkOutput("stream.frames", frameCnt, 10);

        // Asynchronous reset with nine words stored.
        for (int b = 0; b < 3; b++) applyStimulus(1, makeBatch(16'h5000 + b * LANES), 0);
        for (int n = 0; n < 3; n++) applyStimulus(0, '0, 1);
        checkModel("pre_reset");
        checkOutput("pre_reset.level9", level, 9);
        rst_n = 1'b0;
        #2;
        checkResetState("async_reset");
        mq.delete();
        mLevel = 0;
        mReads = 0;
        mDout  = '0;
        mValid = 0;
        mFrame = 0;
`ifdef BATCH_SER_ERR_EN
        mOvf = 0;
        mUnf = 0;
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("post_reset");
        applyStimulus(1, makeBatch(16'h7000), 0);
        checkModel("new_wr");
        applyStimulus(0, '0, 1);
        checkModel("new_rd0");
        checkOutput("new_rd0.data", dout, {4'hA, 32'h7000});
        for (int n = 1; n < LANES; n++) begin
            applyStimulus(0, '0, 1);
            checkModel($sformatf("new_rd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/batch_serializer_fifo.md
# batch_serializer_fifo

Parametrised multi-lane gather/serialise FIFO for the 2D DCT datapath. Each accepted write stores one batch of `LANES` parallel products; the block replays them one word per read in lane order (lane 0 first), batch after batch. It sits between the multiplier array and the serial accumulation/transpose stage. It replaces fixed 4×36-bit, 16-entry buffering with circular-buffer semantics, an explicit handshake, a word level count and frame tracking.

## Interface
- `DATA_W`, 36, width of one word
- `LANES`, 4, words per write batch; power of two, ≥2
- `BATCHES`, 4, batch slots held; power of two, ≥2; DEPTH = LANES*BATCHES words
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write request for one batch
- `din`  in  LANES*DATA_W  batch; lane k at bits [k*DATA_W +: DATA_W]
- `wr_ready`  out  1  one free batch slot exists (= !full)
- `rd_en`  in  1  read request for one word
- `dout`  out  DATA_W  registered read data
- `dout_valid`  out  1  one-cycle pulse, dout updated this cycle
- `full`  out  1  level > DEPTH-LANES
- `empty`  out  1  level == 0
- `level`  out  $clog2(DEPTH)+1  words stored
- `frame_done`  out  1  pulse with the dout_valid of every DEPTH-th word read since reset

## Operation
- Storage is circular. `wr_ptr` advances by LANES per accepted write and stays batch-aligned. `rd_ptr` advances by 1 per accepted read. Both wrap modulo DEPTH with no special case.
- Write accepted iff `wr_en && !full`. On accept, din lane k is stored at wr_ptr+k, and level increases by LANES.
- Write with `full` set: dropped, no state change.
- Read accepted iff `rd_en && !empty`. On accept, dout <= mem[rd_ptr], dout_valid=1 next cycle, level decreases by 1.
- Read with `empty` set: ignored. dout holds and dout_valid=0.
- Simultaneous accepted read and write: both take effect, and level changes by LANES-1. Acceptance uses flags from the start of the cycle; a same-cycle read does not free space for a write.
- No bypass: a word written in cycle N is first readable in cycle N+1.
- A frame counter counts accepted reads modulo DEPTH. On wrap to 0, frame_done is pulsed together with that word's dout_valid.
- dout holds its last value between reads.
- Reset mid-operation discards all contents immediately.

## Timing
- Reset values: dout=0, dout_valid=0, frame_done=0, full=0, empty=1, level=0, wr_ready=1; pointers and frame counter are 0.
- full, empty, level and wr_ready are registered and reflect all accepts from the previous edge.
- Read latency: rd_en accepted at edge N gives dout/dout_valid at edge N+1.
- Write-to-output: write at edge N, rd_en at edge N+1, dout at edge N+2.
- Sustained throughput: one batch per LANES cycles in, one word per cycle out, with no bubbles at wrap-around.

## Configuration
- `BATCH_SER_ERR_EN` defined:
  - adds outputs `overflow` (1) and `underflow` (1);
  - `overflow` is set by a write attempted while full, and `underflow` by a read attempted while empty;
  - both are sticky, cleared only by rst, reset value 0.
- Macro undefined: neither port exists, and drops and ignores happen silently.

## Structure
- Package `batch_ser_pkg` holds:
  - the `clog2`-based helper for PTR_W = $clog2(DEPTH) and LVL_W = PTR_W+1;
  - the lane-slice helper function;
  - no fixed widths.
- Sub-module `batch_ser_mem` is the storage array: DEPTH×DATA_W, one LANES-wide aligned write port, one registered read port. The control logic (pointers, level, flags, frame counter) stays in the top.

## Test plan
- Reset, then write one batch {0x1,0x2,0x3,0x4} (defaults) and read 4 times -> dout 1,2,3,4 on consecutive cycles; level 4→0; empty=1 after the last read.
- Write 4 batches with no reads -> full=1 and wr_ready=0 once level=16. A 5th write is dropped, level stays 16, and `overflow`=1 under `BATCH_SER_ERR_EN`.
- With level=12, write and read in the same cycle -> both accepted and level=15. Then with level=13, a write is refused while a concurrent read is accepted, and level=12.
- Stream 40 batches while reading continuously, forcing pointer wrap -> output equals input order with no bubbles; frame_done pulses on reads 16, 32, 48, ….
- Read while empty -> dout unchanged, dout_valid=0, `underflow`=1 when enabled.
- Assert rst low mid-stream with level=9 -> all outputs at reset values immediately (asynchronous). After release, the first write/read pair returns the new data only.
